// File: rtl/debounced_hex_counter_pkg.sv
// -----------------------------------------------------------------------------
// debounced_hex_counter_pkg
//   Shared definitions for the debounced hex counter:
//     - debouncer state encoding (2 bits)
//     - default debounce length (1 ms at 50 MHz)
//     - the counter step rule, as a pure function used by the top level
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package debounced_hex_counter_pkg;

    // Per-button debouncer states.
    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_CHK_PRESS = 2'd1,
        DB_PRESSED   = 2'd2,
        DB_CHK_REL   = 2'd3
    } db_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Result of one counter update.
    typedef struct packed {
        logic [3:0] value;
        logic       changed;
        logic       limit;
    } count_step_t;

    // One counter update from the debounced press pulses.
    // Clear wins over everything; up and down together cancel out.
    // Wrapping relies on plain 4-bit modulo arithmetic.
    function automatic count_step_t count_step(
        input logic [3:0] value,
        input logic       up,
        input logic       down,
        input logic       clr,
        input logic       wrap
    );
        count_step_t r;
        r.value   = value;
        r.changed = 1'b0;
        r.limit   = 1'b0;
        if (clr) begin
            r.value   = 4'h0;
            r.changed = (value != 4'h0);
        end else if (up && !down) begin
            r.limit = (value == 4'hF);
            if (!r.limit || wrap) begin
                r.value   = value + 4'h1;
                r.changed = 1'b1;
            end
        end else if (down && !up) begin
            r.limit = (value == 4'h0);
            if (!r.limit || wrap) begin
                r.value   = value - 4'h1;
                r.changed = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounced_hex_counter_if.sv
// -----------------------------------------------------------------------------
// debounced_hex_counter_if
//   Groups the raw buttons and the counter outputs.
//     btn_up / btn_down / btn_clr : raw active-high buttons (asynchronous, bouncing)
//     value[3:0]                  : current count, feeds the seven-segment decoder
//     changed                     : one-cycle pulse when value takes a new value
//     limit                       : one-cycle pulse when a step wrapped or saturated
//   master: board/stimulus side (drives buttons); slave: the counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface debounced_hex_counter_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [3:0] value;
    logic       changed;
    logic       limit;

    modport master (
        output btn_up, btn_down, btn_clr,
        input  value, changed, limit
    );

    modport slave (
        input  btn_up, btn_down, btn_clr,
        output value, changed, limit
    );
endinterface

// File: rtl/debounced_hex_counter_button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   2-flop synchroniser followed by a four-state debounce FSM.
//   A level change is accepted only after DEBOUNCE_CYCLES consecutive stable
//   synchronised samples (DEBOUNCE_CYCLES must be >= 2).
//   Ports:
//     clk         : system clock
//     reset_n     : asynchronous active-low reset
//     raw         : raw button, asynchronous to clk
//     press_pulse : registered one-cycle pulse per accepted press
//     level       : debounced button level
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module button_debouncer
    import debounced_hex_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press_pulse,
    output logic level
);

    localparam int unsigned           CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; that is what makes this a
    // two-stage synchroniser rather than a single wire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DB_IDLE;
            cnt_q       <= '0;
            press_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_pulse <= press_d;
        end
    end

    // cnt counts stable samples seen so far; the sample that leaves IDLE or
    // PRESSED is the first one, so the switch happens when cnt hits N-1 with
    // the level still held (the N-th stable sample).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case below can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            DB_IDLE: begin
                if (sync_q2) begin
                    state_d = DB_CHK_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_CHK_PRESS: begin
                if (!sync_q2) begin
                    state_d = DB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_PRESSED: begin
                if (!sync_q2) begin
                    state_d = DB_CHK_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_CHK_REL: begin
                if (sync_q2) begin
                    state_d = DB_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = DB_IDLE;
        endcase
    end

    assign level = (state_q == DB_PRESSED) || (state_q == DB_CHK_REL);

endmodule

// File: rtl/debounced_hex_counter.sv
// -----------------------------------------------------------------------------
// debounced_hex_counter
//   Debounces three raw buttons (up/down/clear) and runs a 0..15 up/down
//   counter whose value feeds the seven-segment decoder input.
//   Parameters:
//     DEBOUNCE_CYCLES : stable cycles needed to accept a button change (>= 2)
//     WRAP            : 1 wraps 15<->0, 0 saturates at 15 and 0
//   Ports:
//     clk     : system clock
//     reset_n : asynchronous active-low reset
//     bus     : slave side of debounced_hex_counter_if (buttons in,
//               value/changed/limit out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module debounced_hex_counter
    import debounced_hex_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          WRAP            = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    debounced_hex_counter_if.slave    bus
);

    logic        up_pulse;
    logic        down_pulse;
    logic        clr_pulse;
    // Debounced levels are not needed by the counter.
    logic [2:0]  unused_level;

    logic [3:0]  value_q;
    logic        changed_q;
    logic        limit_q;
    count_step_t step;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (bus.btn_up),
        .press_pulse (up_pulse),
        .level       (unused_level[0])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (bus.btn_down),
        .press_pulse (down_pulse),
        .level       (unused_level[1])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (bus.btn_clr),
        .press_pulse (clr_pulse),
        .level       (unused_level[2])
    );

    always_comb step = count_step(value_q, up_pulse, down_pulse, clr_pulse, WRAP);

    // changed/limit are registered alongside value, so they pulse in exactly
    // the cycle the new value appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q   <= 4'h0;
            changed_q <= 1'b0;
            limit_q   <= 1'b0;
        end else begin
            value_q   <= step.value;
            changed_q <= step.changed;
            limit_q   <= step.limit;
        end
    end

    assign bus.value   = value_q;
    assign bus.changed = changed_q;
    assign bus.limit   = limit_q;

endmodule

// File: tb/tb_debounced_hex_counter.sv
// -----------------------------------------------------------------------------
// tb_debounced_hex_counter
//   Drives one stimulus into two counters (WRAP=1 and WRAP=0) with
//   DEBOUNCE_CYCLES=4. A behavioural model derives press events from the raw
//   button history (N consecutive stable synchronised samples flip the level)
//   and applies the counter rules; a compare process checks both DUTs against
//   it on every falling edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_debounced_hex_counter;

    localparam int unsigned DB = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic up      = 1'b0;
    logic down    = 1'b0;
    logic clr     = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    debounced_hex_counter_if bus_w ();
    debounced_hex_counter_if bus_s ();

    assign bus_w.btn_up   = up;
    assign bus_w.btn_down = down;
    assign bus_w.btn_clr  = clr;
    assign bus_s.btn_up   = up;
    assign bus_s.btn_down = down;
    assign bus_s.btn_clr  = clr;

    debounced_hex_counter #(.DEBOUNCE_CYCLES(DB), .WRAP(1'b1)) dut_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_w)
    );

    debounced_hex_counter #(.DEBOUNCE_CYCLES(DB), .WRAP(1'b0)) dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    int m_val [2];
    bit m_chg [2];
    bit m_lim [2];
    bit sy1   [3];
    bit sy2   [3];
    bit lvl   [3];
    bit pend  [3];
    bit npend [3];
    bit raw   [3];
    int run   [3];

    function automatic void apply(input int v, input bit wrap, input bit u, input bit d,
                                  input bit c, output int nv, output bit ch, output bit lim);
        nv  = v;
        ch  = 1'b0;
        lim = 1'b0;
        if (c) begin
            nv = 0;
            ch = (v != 0);
        end else if (u && !d) begin
            if (v == 15) begin
                lim = 1'b1;
                nv  = wrap ? 0 : 15;
            end else begin
                nv = v + 1;
            end
            ch = (nv != v);
        end else if (d && !u) begin
            if (v == 0) begin
                lim = 1'b1;
                nv  = wrap ? 15 : 0;
            end else begin
                nv = v - 1;
            end
            ch = (nv != v);
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_val[i] = 0;
                m_chg[i] = 1'b0;
                m_lim[i] = 1'b0;
            end
            for (int b = 0; b < 3; b++) begin
                sy1[b]  = 1'b0;
                sy2[b]  = 1'b0;
                lvl[b]  = 1'b0;
                pend[b] = 1'b0;
                run[b]  = 0;
            end
        end else begin
            // Counter applies the presses accepted on the previous edge.
            for (int i = 0; i < 2; i++) begin
                apply(m_val[i], (i == 0), pend[0], pend[1], pend[2],
                      m_val[i], m_chg[i], m_lim[i]);
            end
            raw[0] = up;
            raw[1] = down;
            raw[2] = clr;
            for (int b = 0; b < 3; b++) begin
                bit s;
                s      = sy2[b];
                sy2[b] = sy1[b];
                sy1[b] = raw[b];
                if (s != lvl[b]) run[b]++;
                else             run[b] = 0;
                npend[b] = 1'b0;
                if (run[b] == DB) begin
                    lvl[b]   = s;
                    run[b]   = 0;
                    npend[b] = s;
                end
            end
            pend = npend;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("cmp.wrap.value",   int'(bus_w.value),   m_val[0]);
            check("cmp.wrap.changed", int'(bus_w.changed), int'(m_chg[0]));
            check("cmp.wrap.limit",   int'(bus_w.limit),   int'(m_lim[0]));
            check("cmp.sat.value",    int'(bus_s.value),   m_val[1]);
            check("cmp.sat.changed",  int'(bus_s.changed), int'(m_chg[1]));
            check("cmp.sat.limit",    int'(bus_s.limit),   int'(m_lim[1]));
        end
    end

    // --------------------------------------------------------- directed part
    int pc_chg [2];
    int pc_lim [2];

    task automatic tally();
        pc_chg[0] += int'(bus_w.changed);
        pc_chg[1] += int'(bus_s.changed);
        pc_lim[0] += int'(bus_w.limit);
        pc_lim[1] += int'(bus_s.limit);
    endtask

    // Press the given buttons together, hold, release, and let release settle.
    task automatic press(input bit u, input bit d, input bit c, input int hold);
        pc_chg = '{0, 0};
        pc_lim = '{0, 0};
        @(posedge clk); #1;
        up = u; down = d; clr = c;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tally();
        end
        up = 1'b0; down = 1'b0; clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            tally();
        end
    endtask

    task automatic expect_press(input string name, input int vw, input int cw, input int lw,
                                input int vs, input int cs, input int ls);
        check({name, ".wrap.value"},   int'(bus_w.value), vw);
        check({name, ".wrap.changed"}, pc_chg[0],         cw);
        check({name, ".wrap.limit"},   pc_lim[0],         lw);
        check({name, ".sat.value"},    int'(bus_s.value), vs);
        check({name, ".sat.changed"},  pc_chg[1],         cs);
        check({name, ".sat.limit"},    pc_lim[1],         ls);
    endtask

    initial begin
        int lat;
        int nchg;

        // Reset state.
        #2 reset_n = 1'b0;
        #1;
        check("reset.value",   int'(bus_w.value),   0);
        check("reset.changed", int'(bus_w.changed), 0);
        check("reset.limit",   int'(bus_w.limit),   0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // Clean press held 20 cycles: value 0->1 seven edges after the raw edge.
        @(posedge clk); #1;
        up   = 1'b1;
        lat  = -1;
        nchg = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            nchg += int'(bus_w.changed);
            if (lat < 0 && bus_w.value != 4'h0) lat = n;
        end
        up = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            nchg += int'(bus_w.changed);
        end
        check("clean.latency", lat, 7);
        check("clean.changed_pulses", nchg, 1);
        check("clean.value", int'(bus_w.value), 1);

        // Bouncing input: two cycles high, two low, for 30 cycles.
        nchg = 0;
        for (int n = 0; n < 42; n++) begin
            @(posedge clk); #1;
            up = (n < 30) ? (((n / 2) % 2) == 0) : 1'b0;
            nchg += int'(bus_w.changed) + int'(bus_s.changed);
        end
        check("bounce.changed_pulses", nchg, 0);
        check("bounce.wrap.value", int'(bus_w.value), 1);
        check("bounce.sat.value",  int'(bus_s.value), 1);

        press(1'b0, 1'b0, 1'b1, 10);
        expect_press("clr1", 0, 1, 0, 0, 1, 0);

        // Down from 0: wraps to 15 or saturates at 0.
        press(1'b0, 1'b1, 1'b0, 10);
        expect_press("down_at_0", 15, 1, 1, 0, 0, 1);

        // Up: wrap instance 15->0, saturating instance 0->1.
        press(1'b1, 1'b0, 1'b0, 10);
        expect_press("up_at_15", 0, 1, 1, 1, 1, 0);

        press(1'b0, 1'b0, 1'b1, 10);
        expect_press("clr2", 0, 0, 0, 0, 1, 0);

        for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0, 10);
        check("five_ups.wrap.value", int'(bus_w.value), 5);
        check("five_ups.sat.value",  int'(bus_s.value), 5);

        press(1'b1, 1'b1, 1'b0, 10);
        expect_press("up_and_down", 5, 0, 0, 5, 0, 0);

        press(1'b1, 1'b0, 1'b1, 10);
        expect_press("clr_and_up", 0, 1, 0, 0, 1, 0);

        for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 1'b0, 10);
        check("seven_ups.value", int'(bus_w.value), 7);

        // Reset mid-debounce: outputs clear without a clock edge, and a
        // button still held must be fully re-qualified afterwards.
        @(posedge clk); #1;
        up = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midreset.wrap.value",   int'(bus_w.value),   0);
        check("midreset.wrap.changed", int'(bus_w.changed), 0);
        check("midreset.wrap.limit",   int'(bus_w.limit),   0);
        check("midreset.sat.value",    int'(bus_s.value),   0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (lat < 0 && bus_w.value != 4'h0) lat = n;
        end
        up = 1'b0;
        repeat (12) @(posedge clk);
        check("requalify.latency", lat, 7);
        check("requalify.value", int'(bus_w.value), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
